load_store_unit: RTL

- Sits between the multicycle control unit / datapath and the system data bus.
- Turns the control unit's memory request into a single registered, Wishbone-classic style bus cycle: rd_en/wr_en, contiguous byte mask, address, store data.
- Aligns store data and byte selects to the word lane; aligns and sign/zero-extends load data.
- Detects misaligned accesses without issuing a bus cycle, and returns a one-cycle mem_ack to the requester.

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a control-unit memory request into one registered
// Wishbone-classic bus cycle, with lane alignment, load extension and misalignment faults.
module load_store_unit #(
   parameter int DATA_SIZE = 32,
   parameter int BYTE_NUM  = DATA_SIZE / 8,
   parameter int OFFSET_W  = $clog2(BYTE_NUM)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [BYTE_NUM-1:0]  byte_en,
   input  logic                 unsigned_load,
   input  logic [DATA_SIZE-1:0] addr,
   input  logic [DATA_SIZE-1:0] wr_data,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 mem_ack,
   output logic                 misaligned,
   output logic                 bus_cyc,
   output logic                 bus_stb,
   output logic                 bus_we,
   output logic [BYTE_NUM-1:0]  bus_sel,
   output logic [DATA_SIZE-1:0] bus_addr,
   output logic [DATA_SIZE-1:0] bus_dat_o,
   input  logic [DATA_SIZE-1:0] bus_dat_i,
   input  logic                 bus_ack
);

   localparam int LOG_W = OFFSET_W + 1;

   typedef enum logic [1:0] {IDLE, BUS, DONE, FAULT} state_t;

   state_t               state_q;
   logic [OFFSET_W-1:0]  off_q;
   logic [LOG_W-1:0]     log_q;
   logic                 unsigned_q;
   logic                 we_q;
   logic [DATA_SIZE-1:0] rd_data_q;
   logic                 mem_ack_q;
   logic                 misaligned_q;
   logic                 bus_cyc_q;
   logic                 bus_we_q;
   logic [BYTE_NUM-1:0]  bus_sel_q;
   logic [DATA_SIZE-1:0] bus_addr_q;
   logic [DATA_SIZE-1:0] bus_dat_q;

   logic [BYTE_NUM-1:0]  req_mask;
   logic [LOG_W-1:0]     req_log;
   logic [OFFSET_W-1:0]  req_align;
   logic [OFFSET_W-1:0]  req_off;
   logic                 req_misaligned;
   logic                 req_we;

   logic [DATA_SIZE-1:0] lane_data;
   logic [DATA_SIZE-1:0] load_keep;
   logic [DATA_SIZE-1:0] load_ext;

   // Unrecognised byte_en patterns fall back to a full-width access.
   always_comb begin
      req_mask  = '1;
      req_log   = LOG_W'(OFFSET_W);
      req_align = '1;
      for (int s = 0; s < OFFSET_W; s++) begin
         if (byte_en == BYTE_NUM'((1 << (1 << s)) - 1)) begin
            req_mask  = byte_en;
            req_log   = LOG_W'(s);
            req_align = OFFSET_W'((1 << s) - 1);
         end
      end
   end

   assign req_off        = addr[OFFSET_W-1:0];
   assign req_misaligned = |(req_off & req_align);
   assign req_we         = wr_en & ~rd_en;

   assign lane_data = bus_dat_i >> {off_q, 3'b000};

   // Full-width loads keep every bit; narrower ones are masked then extended.
   always_comb begin
      load_keep = '1;
      load_ext  = lane_data;
      for (int s = 0; s < OFFSET_W; s++) begin
         if (log_q == LOG_W'(s)) begin
            load_keep = {DATA_SIZE{1'b1}} >> (DATA_SIZE - (8 << s));
            load_ext  = lane_data & load_keep;
            if (!unsigned_q && lane_data[(8 << s) - 1])
               load_ext = load_ext | ~load_keep;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         off_q        <= '0;
         log_q        <= '0;
         unsigned_q   <= 1'b0;
         we_q         <= 1'b0;
         rd_data_q    <= '0;
         mem_ack_q    <= 1'b0;
         misaligned_q <= 1'b0;
         bus_cyc_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_sel_q    <= '0;
         bus_addr_q   <= '0;
         bus_dat_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rd_en || wr_en) begin
                  off_q      <= req_off;
                  log_q      <= req_log;
                  unsigned_q <= unsigned_load;
                  we_q       <= req_we;
                  if (req_misaligned) begin
                     state_q      <= FAULT;
                     mem_ack_q    <= 1'b1;
                     misaligned_q <= 1'b1;
                  end else begin
                     state_q    <= BUS;
                     bus_cyc_q  <= 1'b1;
                     bus_we_q   <= req_we;
                     bus_sel_q  <= req_mask << req_off;
                     bus_addr_q <= {addr[DATA_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
                     bus_dat_q  <= wr_data << {req_off, 3'b000};
                  end
               end
            end
            BUS: begin
               if (bus_ack) begin
                  state_q    <= DONE;
                  mem_ack_q  <= 1'b1;
                  bus_cyc_q  <= 1'b0;
                  bus_we_q   <= 1'b0;
                  bus_sel_q  <= '0;
                  bus_addr_q <= '0;
                  bus_dat_q  <= '0;
                  if (!we_q)
                     rd_data_q <= load_ext;
               end
            end
            DONE, FAULT: begin
               state_q      <= IDLE;
               mem_ack_q    <= 1'b0;
               misaligned_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_data    = rd_data_q;
   assign mem_ack    = mem_ack_q;
   assign misaligned = misaligned_q;
   assign bus_cyc    = bus_cyc_q;
   assign bus_stb    = bus_cyc_q;
   assign bus_we     = bus_we_q;
   assign bus_sel    = bus_sel_q;
   assign bus_addr   = bus_addr_q;
   assign bus_dat_o  = bus_dat_q;

endmodule
